instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'hBFC00000, the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk_enable, input, 1, the global advance enable.
REQ-005 The block SHALL have port mem_address, output, 32, the instruction bus read address, always word aligned.
REQ-006 The block SHALL have port mem_read, output, 1, the instruction bus read request.
REQ-007 The block SHALL have port mem_waitrequest, input, 1, the bus stall; a read completes in a cycle with mem_read=1 and mem_waitrequest=0.
REQ-008 The block SHALL have port mem_readdata, input, 32, the read data, valid in the completing cycle.
REQ-009 The block SHALL have port branch_taken, input, 1, a one-cycle redirect pulse from decode/execute.
REQ-010 The block SHALL have port branch_target, input, 32, the redirect address; bits [1:0] are ignored and forced to 0.
REQ-011 The block SHALL have port instr_valid, output, 1, indicating that instr/instr_pc hold a fetched instruction.
REQ-012 The block SHALL have port instr_ready, input, 1, the downstream accept; the instruction transfers when instr_valid=1 and instr_ready=1.
REQ-013 The block SHALL have port instr, output, 32, the fetched instruction word.
REQ-014 The block SHALL have port instr_pc, output, 32, the address that instr was fetched from.

Function
REQ-015 The block SHALL implement FSM states IDLE, REQ and HOLD, plus a 32-bit fetch PC register and a pending-redirect register pair (flag, target).
REQ-016 The IDLE state SHALL drive mem_read=0 and SHALL go to REQ on the first cycle with clk_enable=1.
REQ-017 The REQ state SHALL drive mem_read=1 with mem_address equal to the fetch PC, and SHALL hold both stable while mem_waitrequest=1.
REQ-018 On read completion, the block SHALL capture instr<=mem_readdata and instr_pc<=fetch PC and go to HOLD, with instr_valid=1 from the next cycle (one-cycle latency); read completion SHALL NOT be gated by clk_enable.
REQ-019 On read completion, the next fetch PC SHALL be the pending target if one is pending (clearing the flag), else fetch PC+4 modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-020 The HOLD state SHALL drive instr_valid=1 and mem_read=0, and SHALL hold instr/instr_pc stable until a transfer occurs.
REQ-021 A HOLD-state transfer with clk_enable=1 SHALL go to REQ next cycle with instr_valid=0; with clk_enable=0 the block SHALL remain in HOLD and no transfer SHALL be counted.
REQ-022 A branch_taken=1 cycle SHALL record the target as pending; the instruction in flight or held (the delay slot) SHALL still be delivered unmodified.
REQ-023 A second branch_taken while one is pending SHALL overwrite the pending target.
REQ-024 A branch_taken in the same cycle as read completion SHALL redirect the fetch PC directly to the new target, without becoming pending.
REQ-025 The minimum throughput SHALL be one instruction per 2 cycles with mem_waitrequest=0 and instr_ready=1.

Reset
REQ-026 Reset assertion SHALL immediately force state=IDLE, mem_read=0, instr_valid=0, instr=0, instr_pc=0, fetch PC=RESET_VECTOR (mem_address=RESET_VECTOR) and pending flag=0.
REQ-027 A reset during an outstanding read SHALL abandon that read, discarding any late data.
REQ-028 The first read after reset release SHALL be issued at RESET_VECTOR.

Configuration
REQ-029 With the macro FETCH_TRACE_EN defined, each read completion SHALL print "CPU : IF : <addr hex> <instr hex>" via $display.
REQ-030 Without FETCH_TRACE_EN, the block SHALL produce no simulation output; synthesised logic SHALL be identical in both cases.

Verification
REQ-031 Reset, release, clk_enable=1, zero-wait memory -> first read at 32'hBFC00000; instr_valid rises 2 cycles after release with instr_pc=BFC00000.
REQ-032 Three fetches with mem_waitrequest=1 for 3 cycles each -> mem_address stable during the stall; instr_pc sequence BFC00000, BFC00004, BFC00008.
REQ-033 branch_taken with target 32'h00400013 while reading BFC00004 -> BFC00004 delivered, next read at 00400010.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc unchanged, mem_read=0 throughout.
REQ-035 Fetch PC FFFFFFFC completes -> next mem_address 00000000.
REQ-036 Reset asserted mid-read -> mem_read=0 immediately; next read at BFC00000; the stale completion produces no instr_valid.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC, single-outstanding bus read, branch redirect with delay slot.
// Define FETCH_TRACE_EN to print each completed fetch (simulation only).
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            mem_read_nxt;
  logic            instr_valid_nxt;
  logic [XLEN-1:0] pc;
  logic            pend_flag;
  logic [XLEN-1:0] pend_target;
  logic            rd_done_c;
  logic            xfer_c;
  logic [XLEN-1:0] target_c;

  assign rd_done_c   = (state == REQ) && !mem_waitrequest;
  assign xfer_c      = (state == HOLD) && instr_ready && clk_enable;
  assign target_c    = branch_target & ALIGN_MASK;
  assign mem_address = pc;

  // State register; handshake outputs are registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_read    <= mem_read_nxt;
      instr_valid <= instr_valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clk_enable) state_nxt = REQ;
      REQ:     if (rd_done_c)  state_nxt = HOLD;
      HOLD:    if (xfer_c)     state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read_nxt    = 1'b0;
    instr_valid_nxt = 1'b0;
    unique case (state_nxt)
      REQ:     mem_read_nxt    = 1'b1;
      HOLD:    instr_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  // Fetch PC, pending redirect and captured instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      pend_flag   <= 1'b0;
      pend_target <= '0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      if (rd_done_c) begin
        instr    <= mem_readdata;
        instr_pc <= pc;
        // A branch arriving with completion wins over any older pending target.
        if (branch_taken)   pc <= target_c;
        else if (pend_flag) pc <= pend_target;
        else                pc <= pc + XLEN'(4);
        pend_flag <= 1'b0;
      end else if (branch_taken) begin
        pend_flag   <= 1'b1;
        pend_target <= target_c;
      end
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && rd_done_c) $display("CPU : IF : %h %h", pc, mem_readdata);
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a zero/variable-wait memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_1234;
  endfunction

  assign mem_readdata = word_at(mem_address);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b0; mem_waitrequest = 1'b0;
    branch_taken = 1'b0; branch_target = '0; instr_ready = 1'b1;
    tick(); tick();
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_addr", mem_address, 32'hBFC00000);

    // Release and first zero-wait fetch
    reset = 1'b0; clk_enable = 1'b1;
    tick();
    check("first_req", 32'(mem_read), 32'd1);
    check("first_addr", mem_address, 32'hBFC00000);
    check("first_valid_lo", 32'(instr_valid), 32'd0);
    tick();
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_pc", instr_pc, 32'hBFC00000);
    check("first_instr", instr, word_at(32'hBFC00000));
    check("first_hold_rd", 32'(mem_read), 32'd0);

    // Second fetch stalled 3 cycles
    tick();
    check("f2_addr", mem_address, 32'hBFC00004);
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("f2_stall_rd", 32'(mem_read), 32'd1);
      check("f2_stall_addr", mem_address, 32'hBFC00004);
      check("f2_stall_valid", 32'(instr_valid), 32'd0);
    end
    mem_waitrequest = 1'b0;
    tick();
    check("f2_pc", instr_pc, 32'hBFC00004);
    check("f2_instr", instr, word_at(32'hBFC00004));

    // Third fetch stalled; branch recorded as pending during the stall
    tick();
    check("f3_addr", mem_address, 32'hBFC00008);
    mem_waitrequest = 1'b1; branch_taken = 1'b1; branch_target = 32'h00400013;
    tick();
    branch_taken = 1'b0;
    tick(); tick();
    check("f3_stall_addr", mem_address, 32'hBFC00008);
    mem_waitrequest = 1'b0;
    tick();
    check("delay_slot_pc", instr_pc, 32'hBFC00008);
    check("delay_slot_instr", instr, word_at(32'hBFC00008));
    tick();
    check("branch_addr", mem_address, 32'h00400010);
    check("branch_rd", 32'(mem_read), 32'd1);

    // Branch coincident with completion redirects directly
    branch_taken = 1'b1; branch_target = 32'hFFFFFFFF; instr_ready = 1'b0;
    tick();
    branch_taken = 1'b0;
    check("direct_pc", instr_pc, 32'h00400010);
    check("direct_next_addr", mem_address, 32'hFFFFFFFC);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_pc", instr_pc, 32'h00400010);
      check("hold_instr", instr, word_at(32'h00400010));
      check("hold_rd", 32'(mem_read), 32'd0);
      check("hold_valid", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1; clk_enable = 1'b0;
    tick();
    check("noen_valid", 32'(instr_valid), 32'd1);
    check("noen_rd", 32'(mem_read), 32'd0);
    clk_enable = 1'b1;
    tick();
    check("wrap_req_addr", mem_address, 32'hFFFFFFFC);
    check("wrap_req_rd", 32'(mem_read), 32'd1);
    check("wrap_req_valid", 32'(instr_valid), 32'd0);
    tick();
    check("wrap_pc", instr_pc, 32'hFFFFFFFC);
    tick();
    check("wrap_addr", mem_address, 32'h00000000);
    check("wrap_rd", 32'(mem_read), 32'd1);

    // Second branch overwrites pending target
    mem_waitrequest = 1'b1; branch_taken = 1'b1; branch_target = 32'h00000100;
    tick();
    branch_target = 32'h00000206;
    tick();
    branch_taken = 1'b0; mem_waitrequest = 1'b0;
    tick();
    check("ovw_pc", instr_pc, 32'h00000000);
    tick();
    check("ovw_addr", mem_address, 32'h00000204);

    // Reset mid-read; late completion must be discarded
    mem_waitrequest = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_rd", 32'(mem_read), 32'd0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_addr", mem_address, 32'hBFC00000);
    mem_waitrequest = 1'b0; clk_enable = 1'b0;
    tick(); tick();
    check("stale_valid", 32'(instr_valid), 32'd0);
    check("stale_instr", instr, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_rd", 32'(mem_read), 32'd0);
    clk_enable = 1'b1;
    tick();
    check("rel_rd", 32'(mem_read), 32'd1);
    check("rel_addr", mem_address, 32'hBFC00000);
    tick();
    check("rel_valid", 32'(instr_valid), 32'd1);
    check("rel_pc", instr_pc, 32'hBFC00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
